// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller for the 5-stage MIPS core: forwarding, load/branch/MDU/HI-LO
// stalls, per-stage stall/flush with exception and memory-wait priority, saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              mdreadD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              mdstartE,
  input  logic              mddivE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              exceptM,
  input  logic              ext_stall,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              mdbusy,
  output logic              mddone,
  output logic              mdcancel,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int LAT_W   = ($clog2(MAX_LAT + 1) > 8) ? $clog2(MAX_LAT + 1) : 8;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } mdState_e;

  mdState_e         state_r, stateNext_s;
  logic [LAT_W-1:0] cnt_r, cntNext_s;
  logic             ldStall_s, brStall_s, mdStall_s, hiloStall_s;
  logic             eMatchD_s, mMatchD_s;

  // Operand forwarding: M has priority over W, register zero never forwards.
  always_comb begin
    forwardaD = (rsD != ZERO_REG) && regwriteM && (writeregM == rsD);
    forwardbD = (rtD != ZERO_REG) && regwriteM && (writeregM == rtD);
    forwardaE = 2'b00;
    forwardbE = 2'b00;
    if ((rsE != ZERO_REG) && regwriteM && (writeregM == rsE)) begin
      forwardaE = 2'b10;
    end else if ((rsE != ZERO_REG) && regwriteW && (writeregW == rsE)) begin
      forwardaE = 2'b01;
    end else begin
      forwardaE = 2'b00;
    end
    if ((rtE != ZERO_REG) && regwriteM && (writeregM == rtE)) begin
      forwardbE = 2'b10;
    end else if ((rtE != ZERO_REG) && regwriteW && (writeregW == rtE)) begin
      forwardbE = 2'b01;
    end else begin
      forwardbE = 2'b00;
    end
  end

  assign mdbusy   = (state_r != MD_IDLE);
  assign mddone   = (state_r == MD_DONE);
  assign mdcancel = exceptM && (state_r != MD_IDLE);

  // Individual hazard conditions.
  always_comb begin
    eMatchD_s   = (writeregE == rsD) || (writeregE == rtD);
    mMatchD_s   = (writeregM == rsD) || (writeregM == rtD);
    ldStall_s   = memtoregE && regwriteE && (writeregE != ZERO_REG) && eMatchD_s;
    brStall_s   = branchD && ((regwriteE && (writeregE != ZERO_REG) && eMatchD_s) ||
                              (memtoregM && (writeregM != ZERO_REG) && mMatchD_s));
    mdStall_s   = ((state_r == MD_IDLE) && mdstartE) || (state_r == MD_BUSY);
    hiloStall_s = mdreadD && (mdbusy || mdstartE);
  end

  // Stage stall/flush resolution: exception beats memory wait beats hazards.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (ext_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else begin
      stallE = mdStall_s;
      stallD = mdStall_s | ldStall_s | brStall_s | hiloStall_s;
      stallF = stallD;
      flushE = stallD & ~stallE;
      flushM = stallE;
    end
  end

  // MDU latency FSM next state; DONE holds while E is stalled.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    if (exceptM) begin
      stateNext_s = MD_IDLE;
      cntNext_s   = '0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (mdstartE) begin
            stateNext_s = MD_BUSY;
            cntNext_s   = mddivE ? LAT_W'(DIV_CYCLES - 1) : LAT_W'(MUL_CYCLES - 1);
          end else begin
            stateNext_s = MD_IDLE;
          end
        end
        MD_BUSY: begin
          if (cnt_r == '0) begin
            stateNext_s = MD_DONE;
          end else begin
            cntNext_s = cnt_r - LAT_W'(1);
          end
        end
        MD_DONE: begin
          if (!stallE) begin
            stateNext_s = MD_IDLE;
          end else begin
            stateNext_s = MD_DONE;
          end
        end
        default: begin
          stateNext_s = MD_IDLE;
          cntNext_s   = '0;
        end
      endcase
    end
  end

  // MDU state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= MD_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Saturating count of cycles spent with D stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stallD && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. Successor to the combinational hazard unit.
- Adds parametrised register-address width and an internal multiply/divide latency FSM, which replaces the external "mul/div computing" input.
- Adds HI/LO read-after-MDU stalls, per-stage decoupled stall/flush, external memory-wait stall, exception flush and a saturating stall-cycle counter.
- Sits beside the datapath; all outputs feed the pipeline registers and forwarding muxes.

Parameters:
REG_AW, 5, register-address width; register 0 is hardwired zero
MUL_CYCLES, 2, multiply latency LAT (>=1)
DIV_CYCLES, 32, divide latency LAT (>=1)
CNT_W, 32, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-low reset
rsD, rtD  in  REG_AW  D-stage source registers
branchD  in  1  branch compare in D
mdreadD  in  1  mfhi/mflo in D
rsE, rtE, writeregE  in  REG_AW  E-stage sources and destination
regwriteE, memtoregE  in  1  E-stage write / load
mdstartE  in  1  mult/div instruction in E
mddivE  in  1  1 = divide, 0 = multiply
writeregM  in  REG_AW  M-stage destination
regwriteM, memtoregM  in  1  M-stage write / load
writeregW  in  REG_AW  W-stage destination
regwriteW  in  1  W-stage write
exceptM  in  1  exception committed in M
ext_stall  in  1  memory not ready; freeze whole pipe
forwardaD, forwardbD  out  1  M->D forwarding for branch compare
forwardaE, forwardbE  out  2  00 regfile, 10 from M, 01 from W
stallF, stallD, stallE, stallM, stallW  out  1  hold stage register
flushD, flushE, flushM, flushW  out  1  clear stage register to bubble
mdbusy  out  1  MDU FSM not IDLE
mddone  out  1  MDU result valid this cycle
mdcancel  out  1  one-cycle pulse: MDU op aborted by exception
stall_cycles  out  CNT_W  count of cycles with stallD=1

Behaviour:
- Forwarding (combinational): same as current unit, with M priority over W. A source equal to 0 never forwards. forwardaD/forwardbD use M only.
- ld_stall = memtoregE & regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- br_stall = branchD & ((regwriteE & writeregE!=0 & E-match) | (memtoregM & writeregM!=0 & M-match)). A match is against rsD or rtD.
- MDU FSM states IDLE / BUSY / DONE; 8-bit-or-wider down-counter cnt.
  - IDLE & mdstartE: go to BUSY, cnt <= LAT-1 (LAT chosen by mddivE).
  - BUSY: cnt decrements; at cnt==0 go to DONE.
  - DONE: mddone=1; go to IDLE when stallE=0, else hold DONE.
- md_stall = (IDLE & mdstartE) | BUSY. An op therefore holds E for exactly LAT+1 cycles, and leaves E in the DONE cycle.
- hilo_stall = mdreadD & (mdbusy | mdstartE).
- Priority 1, exceptM=1: all stalls 0; flushD=flushE=flushM=1; flushW=0. FSM goes to IDLE next edge. mdcancel=1 if FSM was not IDLE.
- Priority 2, ext_stall=1: stallF..stallW all 1; all flushes 0. FSM still counts, but DONE holds.
- Priority 3, otherwise:
  - stallE = md_stall; stallD = stallE | ld_stall | br_stall | hilo_stall; stallF = stallD; stallM = stallW = 0.
  - flushE = stallD & ~stallE; flushM = stallE; flushD = flushW = 0.
- stall_cycles increments on every clock with stallD=1 and saturates at all-ones. It never wraps.
- Reset (async, resetn=0): FSM IDLE, cnt=0, stall_cycles=0. mdbusy, mddone and mdcancel are 0. Combinational outputs follow inputs. Reset mid-divide aborts silently, with no mdcancel.
- mdstartE during DONE is not re-accepted. That is the same instruction still in E.

Test Plan:
- lw $2 in E (writeregE=2, memtoregE=1), rsD=2 -> stallF=stallD=flushE=1, stallE=0; a following cycle with memtoregE=0 clears all.
- rsE=3, writeregM=3 and writeregW=3 both writing -> forwardaE=10. rsE=0 with same M/W -> forwardaE=00.
- mdstartE=1, mddivE=1, DIV_CYCLES=32 -> stallE=1 for 33 cycles, flushM=1 throughout, mddone=1 on cycle 34 with stallE=0, then IDLE; stall_cycles=33.
- mdreadD=1 during BUSY -> stallD=1 until DONE; mfhi proceeds on the cycle after DONE.
- exceptM at BUSY cycle 5 -> flushD/E/M=1, stalls 0, mdcancel pulse, mdbusy=0 next cycle.
- ext_stall held 3 cycles during DONE -> all stalls 1, FSM stays DONE, mddone stays 1; advances to IDLE when released. Force stall_cycles near all-ones (CNT_W=4) -> saturates at 15.
